// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO controller for a single-port 256x13 SRAM macro with 1-cycle read latency.
// One SRAM access per cycle; a 2-entry register buffer absorbs the read latency on the dequeue side.
module sram_fifo_ctrl #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_bits,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {PRI_READ = 1'b0, PRI_WRITE = 1'b1} pri_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   sram_cnt_r;
  logic              inflight_r;
  logic [1:0]        buf_cnt_r;
  logic [DATA_W-1:0] buf0_r;
  logic [DATA_W-1:0] buf1_r;
  logic [ADDR_W+1:0] count_r;
  pri_e              rr_pri_r;

  logic [1:0]        occ_s;
  logic              rd_want_s;
  logic              wr_want_s;
  logic              contended_s;
  logic              rd_grant_s;
  logic              wr_grant_s;
  logic              pop_s;
  logic [1:0]        cap_slot_s;
  logic [ADDR_W:0]   sram_cnt_n_s;
  logic [1:0]        buf_cnt_n_s;
  logic [ADDR_W+1:0] count_n_s;

  // Arbitration between read refill and write; reads only when the buffer has room for the result
  always_comb begin
    occ_s       = buf_cnt_r + {1'b0, inflight_r};
    rd_want_s   = !reset && (sram_cnt_r != (ADDR_W+1)'(0)) && (occ_s < 2'd2);
    wr_want_s   = !reset && enq_valid && (sram_cnt_r < FULL_CNT);
    contended_s = rd_want_s && wr_want_s;
    rd_grant_s  = 1'b0;
    wr_grant_s  = 1'b0;
    if (contended_s) begin
      // an empty output path always wins the port so the consumer is never starved
      if ((occ_s == 2'd0) || (rr_pri_r == PRI_READ)) begin
        rd_grant_s = 1'b1;
      end else begin
        wr_grant_s = 1'b1;
      end
    end else begin
      rd_grant_s = rd_want_s;
      wr_grant_s = wr_want_s;
    end
  end

  // Port outputs and next-state occupancy arithmetic
  always_comb begin
    enq_ready    = !reset && (sram_cnt_r < FULL_CNT) && !rd_grant_s;
    sram_en      = rd_grant_s || wr_grant_s;
    sram_wmode   = wr_grant_s;
    sram_wdata   = enq_bits;
    if (wr_grant_s) begin
      sram_addr = wr_ptr_r;
    end else begin
      sram_addr = rd_ptr_r;
    end
    deq_valid    = !reset && (buf_cnt_r != 2'd0);
    deq_bits     = buf0_r;
    if (reset) begin
      count = (ADDR_W+2)'(0);
    end else begin
      count = count_r;
    end
    pop_s        = (buf_cnt_r != 2'd0) && deq_ready;
    cap_slot_s   = buf_cnt_r - {1'b0, pop_s};
    sram_cnt_n_s = sram_cnt_r + (ADDR_W+1)'(wr_grant_s) - (ADDR_W+1)'(rd_grant_s);
    buf_cnt_n_s  = buf_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    count_n_s    = (ADDR_W+2)'(sram_cnt_n_s) + (ADDR_W+2)'(rd_grant_s) + (ADDR_W+2)'(buf_cnt_n_s);
  end

  // Pointers, occupancy counters and round-robin priority
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= ADDR_W'(0);
      rd_ptr_r   <= ADDR_W'(0);
      sram_cnt_r <= (ADDR_W+1)'(0);
      inflight_r <= 1'b0;
      buf_cnt_r  <= 2'd0;
      count_r    <= (ADDR_W+2)'(0);
      rr_pri_r   <= PRI_READ;
    end else begin
      if (wr_grant_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_grant_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      sram_cnt_r <= sram_cnt_n_s;
      inflight_r <= rd_grant_s;
      buf_cnt_r  <= buf_cnt_n_s;
      count_r    <= count_n_s;
      if (contended_s) begin
        rr_pri_r <= (rr_pri_r == PRI_READ) ? PRI_WRITE : PRI_READ;
      end
    end
  end

  // Output buffer: head shifts on pop, returning read data lands in the first free slot
  always_ff @(posedge clock) begin
    if (reset) begin
      buf0_r <= {DATA_W{1'b0}};
      buf1_r <= {DATA_W{1'b0}};
    end else begin
      if (pop_s && (buf_cnt_r == 2'd2)) begin
        buf0_r <= buf1_r;
      end
      if (inflight_r) begin
        if (cap_slot_s == 2'd0) begin
          buf0_r <= sram_rdata;
        end else begin
          buf1_r <= sram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized bench for sram_fifo_ctrl: a queue-based occupancy model checks every cycle,
// an SRAM macro model serves the port, and directed scenarios pin literal expectations.
module tb_sram_fifo_ctrl;
  localparam int DATA_W = 13;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clock = 1'b0;
  logic              reset;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [ADDR_W+1:0] count;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int checks   = 0;
  int failures = 0;

  sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count), .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // SRAM macro: 1-cycle read latency, read data held until the next read
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      failures++;
      $display("FAIL %s: got %0d expected at least %0d at %0t", name, act, lo, $time);
    end
  endtask

  // Behavioural model: contents as queues, addresses as plain counters modulo DEPTH
  logic [DATA_W-1:0] m_sram_q[$];
  logic [DATA_W-1:0] m_buf_q[$];
  bit                m_infl;
  logic [DATA_W-1:0] m_infl_data;
  bit                m_pri_read;
  int                m_wr_addr;
  int                m_rd_addr;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_bits;
  int                c_occ;
  bit                c_rdw, c_wrw, c_rg, c_wg, c_pop;
  logic [DATA_W-1:0] c_wbits;

  initial begin : compare
    m_infl = 1'b0; m_pri_read = 1'b1; m_wr_addr = 0; m_rd_addr = 0; prev_stall = 1'b0;
    m_infl_data = '0; prev_bits = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("rst_enq_ready", int'(enq_ready), 0);
        chk("rst_deq_valid", int'(deq_valid), 0);
        chk("rst_sram_en", int'(sram_en), 0);
        chk("rst_count", int'(count), 0);
        prev_stall = 1'b0;
        @(posedge clock);
        m_sram_q.delete(); m_buf_q.delete();
        m_infl = 1'b0; m_pri_read = 1'b1; m_wr_addr = 0; m_rd_addr = 0;
      end else begin
        c_occ = m_buf_q.size() + int'(m_infl);
        c_rdw = (m_sram_q.size() > 0) && (c_occ < 2);
        c_wrw = enq_valid && (m_sram_q.size() < DEPTH);
        if (c_rdw && c_wrw) begin
          c_rg = (c_occ == 0) || m_pri_read;
          c_wg = !c_rg;
        end else begin
          c_rg = c_rdw;
          c_wg = c_wrw;
        end
        chk("enq_ready", int'(enq_ready), int'((m_sram_q.size() < DEPTH) && !c_rg));
        chk("sram_en", int'(sram_en), int'(c_rg || c_wg));
        if (c_wg) begin
          chk("wr_wmode", int'(sram_wmode), 1);
          chk("wr_addr", int'(sram_addr), m_wr_addr);
          chk("wr_data", int'(sram_wdata), int'(enq_bits));
        end
        if (c_rg) begin
          chk("rd_wmode", int'(sram_wmode), 0);
          chk("rd_addr", int'(sram_addr), m_rd_addr);
        end
        chk("deq_valid", int'(deq_valid), int'(m_buf_q.size() > 0));
        if (m_buf_q.size() > 0) chk("deq_bits", int'(deq_bits), int'(m_buf_q[0]));
        if (prev_stall) chk("stall_hold", int'(deq_bits), int'(prev_bits));
        chk("count", int'(count), m_sram_q.size() + int'(m_infl) + m_buf_q.size());
        prev_stall = (m_buf_q.size() > 0) && !deq_ready;
        if (m_buf_q.size() > 0) prev_bits = m_buf_q[0];
        c_pop   = (m_buf_q.size() > 0) && deq_ready;
        c_wbits = enq_bits;
        @(posedge clock);
        if (c_pop) void'(m_buf_q.pop_front());
        if (m_infl) m_buf_q.push_back(m_infl_data);
        m_infl = c_rg;
        if (c_rg) begin
          m_infl_data = m_sram_q.pop_front();
          m_rd_addr = (m_rd_addr + 1) % DEPTH;
        end
        if (c_wg) begin
          m_sram_q.push_back(c_wbits);
          m_wr_addr = (m_wr_addr + 1) % DEPTH;
        end
        if (c_rdw && c_wrw) m_pri_read = !m_pri_read;
      end
    end
  end

  int next_val, exp_deq, acc, dlv;

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic look(); @(negedge clock); #1; endtask

  // One cycle per iteration: random valid/ready with given percentages, sequential payloads
  task automatic run(input int n, input int pv, input int pd);
    for (int i = 0; i < n; i++) begin
      enq_valid = (int'($urandom_range(0, 99)) < pv);
      deq_ready = (int'($urandom_range(0, 99)) < pd);
      enq_bits  = DATA_W'(next_val);
      look();
      if (enq_valid && enq_ready) begin next_val++; acc++; end
      if (deq_valid && deq_ready) begin
        chk("order", int'(deq_bits), exp_deq % 8192);
        exp_deq++; dlv++;
      end
      tick();
    end
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (count != '0 && b < 1000) begin run(1, 0, 100); b++; end
    chk(name, int'(count), 0);
  endtask

  initial begin : stim
    int b;
    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
    next_val = 0; exp_deq = 0; acc = 0; dlv = 0;
    repeat (3) tick();
    reset = 1'b0;

    // single word into an empty FIFO: write, read, capture, visible
    enq_valid = 1'b1; enq_bits = 13'h1AB;
    look();
    chk("t1_wr_en", int'(sram_en), 1); chk("t1_wr_mode", int'(sram_wmode), 1);
    chk("t1_wr_addr", int'(sram_addr), 0); chk("t1_wr_data", int'(sram_wdata), 32'h1AB);
    chk("t1_enq_ready", int'(enq_ready), 1);
    tick(); enq_valid = 1'b0;
    look();
    chk("t1_rd_en", int'(sram_en), 1); chk("t1_rd_mode", int'(sram_wmode), 0);
    chk("t1_rd_addr", int'(sram_addr), 0); chk("t1_count_c1", int'(count), 1);
    tick(); look();
    chk("t1_deq_valid_c2", int'(deq_valid), 0); chk("t1_count_c2", int'(count), 1);
    tick(); deq_ready = 1'b1; look();
    chk("t1_deq_valid_c3", int'(deq_valid), 1); chk("t1_deq_bits", int'(deq_bits), 32'h1AB);
    chk("t1_count_c3", int'(count), 1);
    tick(); deq_ready = 1'b0; look();
    chk("t1_count_after", int'(count), 0); chk("t1_empty", int'(deq_valid), 0);
    tick();

    // fill to capacity with no dequeue, then drain in order
    next_val = 0; exp_deq = 0; acc = 0; dlv = 0;
    run(300, 100, 0);
    chk("t2_accepts", acc, 258);
    enq_valid = 1'b1; look();
    chk("t2_full_ready", int'(enq_ready), 0); chk("t2_full_count", int'(count), 258);
    tick();
    drain("t2_drain_count");
    chk("t2_delivered", dlv, 258);

    // three times DEPTH streamed through with random gaps: pointer wrap
    acc = 0; dlv = 0; b = 0;
    while (acc < 3 * DEPTH && b < 4000) begin run(1, 80, 80); b++; end
    drain("t3_drain_count");
    chk_min("t3_accepts", acc, 3 * DEPTH);
    chk("t3_balance", dlv, acc);

    // half full, both streams saturated: port alternates
    b = 0;
    while (count < 10'd128 && b < 400) begin run(1, 100, 0); b++; end
    run(20, 100, 100);
    acc = 0; dlv = 0;
    run(100, 100, 100);
    chk_min("t4_enq_rate", acc, 50);
    chk_min("t4_deq_rate", dlv, 50);
    drain("t4_drain_count");

    // random consumer stalls
    run(400, 50, 30);
    drain("t5_drain_count");

    // reset with five entries held and a read in flight
    acc = 0; b = 0;
    while (acc < 3 && b < 20) begin run(1, 100, 0); b++; end
    run(6, 0, 0);
    acc = 0; b = 0;
    while (acc < 2 && b < 20) begin run(1, 100, 0); b++; end
    chk("t6_count5", int'(count), 5);
    run(1, 100, 100);
    enq_valid = 1'b0; deq_ready = 1'b0; look();
    chk("t6_rd_en", int'(sram_en), 1); chk("t6_rd_mode", int'(sram_wmode), 0);
    chk("t6_count_pre", int'(count), 5);
    tick();
    reset = 1'b1; look();
    chk("t6_rst_count", int'(count), 0); chk("t6_rst_valid", int'(deq_valid), 0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      deq_ready = 1'b1; look();
      chk("t6_no_stale", int'(deq_valid), 0); chk("t6_count0", int'(count), 0);
      tick();
    end
    exp_deq = next_val;
    run(30, 60, 60);
    drain("t6_recover_drain");

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
